touch_led_array: RTL and testbench
==================================

// Module: touch_led_array
// PURPOSE
//  Multi-channel touch-key LED controller. Per channel: 2-FF synchroniser, counter debounce,
//  press/long-press event detection and LED drive in a global mode (toggle, momentary, long-toggle).
//  Sits between board touch pads and user LEDs. Also exports one-cycle press and long-press
//  event pulses to other logic.
// PARAMETERS
//  CH            4            number of key/LED channels (>=1)
//  DEBOUNCE_CYC  1_000_000    cycles the synced key must differ from stable level before accepted (>=2)
//  LONG_CYC      50_000_000   cycles debounced key must stay high to raise long-press (>=1)
//  LED_RST       1'b1         LED level on every channel after reset
// PORTS
//  sys_clk     in   1     system clock
//  sys_rst_n   in   1     asynchronous, active-low reset
//  touch_key   in   CH    raw touch-pad levels, async to sys_clk, 1 = touched
//  mode        in   2     00 TOGGLE, 01 MOMENTARY, 10 LONG_TOGGLE, 11 HOLD (sync, static/slow)
//  led         out  CH    LED drive, registered
//  key_press   out  CH    1-cycle pulse per channel on debounced rising edge
//  key_long    out  CH    1-cycle pulse per channel when long-press threshold reached
// BEHAVIOUR
//  Reset (async, sys_rst_n=0): sync FFs, stable level db, all counters, key_press, key_long = 0.
//  Reset: led = {CH{LED_RST}}. Reset mid-press clears all state. After release, a still-held key
//  is seen as a new press after full debounce.
//  Channels fully independent; simultaneous events on several channels are all handled in the same cycle.
//  Sync: s1<=touch_key, s2<=s1.
//  Debounce counter dcnt (width $clog2(DEBOUNCE_CYC)):
//   - s2==db: dcnt<=0.
//   - s2!=db and dcnt==DEBOUNCE_CYC-1: db<=s2, dcnt<=0.
//   - s2!=db otherwise: dcnt<=dcnt+1.
//   - Hence a pulse or glitch shorter than DEBOUNCE_CYC cycles at s2 is ignored. A bounce restarts the count.
//  Latency: touch_key first sampled high at edge E.
//   - db, key_press and (TOGGLE) led change at edge E+1+DEBOUNCE_CYC.
//   - Release has the same latency.
//  key_press<=1 on the edge db goes 0->1, else 0. No pulse on release.
//  Long counter lcnt (width $clog2(LONG_CYC+1)):
//   - Cleared while db==0.
//   - While db==1, increments until it saturates at LONG_CYC.
//   - key_long<=1 on the edge lcnt steps LONG_CYC-1 -> LONG_CYC. Exactly once per press.
//   - No repeat while held.
//  LED update per channel, evaluated every cycle with current mode:
//   - TOGGLE:       key_press condition -> led<=~led; else hold.
//   - MOMENTARY:    led<=db; next-state value, so it tracks db with the same edge timing as db.
//   - LONG_TOGGLE:  key_long condition -> led<=~led; short presses do not change led.
//   - HOLD (11):    led holds; events still generated.
//  Mode change: led keeps its current value and the new mode acts from the next edge.
//   - Example: entering MOMENTARY forces led=db on the next edge.
//  A press already past debounce when mode switches to TOGGLE does not toggle; only new edges count.
// TESTING  (bench: CH=4, DEBOUNCE_CYC=4, LONG_CYC=16, LED_RST=1)
//  1 Reset, mode=00, hold key[0] high 30 cyc then low:
//    -> key_press[0] one pulse 5 edges after first sample; led=4'b1110 after; no change on release.
//  2 mode=00, key[1] high for 3 cycles only (glitch); also a 2-high/1-low/2-high bounce:
//    -> no key_press, led[1] stays 1, dcnt restarts.
//  3 mode=10, key[2] held 25 cycles:
//    -> key_press[2] once; key_long[2] once 16 edges after db rise; led[2] 1->0 then;
//    -> a 10-cycle press gives no led change.
//  4 mode=01, key[3] high 10 cyc:
//    -> led[3] = db[3], i.e. 1 during debounced press window, 0 otherwise.
//  5 mode=00, all four keys pressed same cycle -> key_press=4'b1111 same cycle, led 4'b1111->4'b0000.
//  6 Assert sys_rst_n=0 mid long-press; release reset while key still held
//    -> led=1111, outputs 0 immediately.
//    -> New key_press after DEBOUNCE_CYC+1 edges; key_long counts from the new db rise.

Source files
------------

// File: rtl/touch_led_array.sv
// Multi-channel touch-key controller: 2-FF sync, counter debounce, press/long-press pulses, LED mode drive.
// Latency: db/key_press/led change DEBOUNCE_CYC+1 edges after first raw sample; key_long LONG_CYC edges after db rise.
// Backpressure: none; event pulses are single-cycle and free-running, consumers must sample every cycle.
module touch_led_array #(
    parameter int   CH           = 4,
    parameter int   DEBOUNCE_CYC = 1_000_000,
    parameter int   LONG_CYC     = 50_000_000,
    parameter logic LED_RST      = 1'b1
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic [CH-1:0] touch_key,
    input  logic [1:0]    mode,
    output logic [CH-1:0] led,
    output logic [CH-1:0] key_press,
    output logic [CH-1:0] key_long
);

    localparam int DW = $clog2(DEBOUNCE_CYC);
    localparam int LW = $clog2(LONG_CYC + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [LW-1:0] LCNT_MAX  = LW'(LONG_CYC);
    localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_CYC - 1);

    localparam logic [1:0] MODE_TOGGLE      = 2'b00;
    localparam logic [1:0] MODE_MOMENTARY   = 2'b01;
    localparam logic [1:0] MODE_LONG_TOGGLE = 2'b10;

    logic [CH-1:0] s1_q, s1_d;
    logic [CH-1:0] s2_q, s2_d;
    logic [CH-1:0] db_q, db_d;
    logic [CH-1:0] led_q, led_d;
    logic [CH-1:0] press_q, press_d;
    logic [CH-1:0] long_q, long_d;
    logic [DW-1:0] dcnt_q [CH];
    logic [DW-1:0] dcnt_d [CH];
    logic [LW-1:0] lcnt_q [CH];
    logic [LW-1:0] lcnt_d [CH];

    always_comb begin
        s1_d    = touch_key;
        s2_d    = s1_q;
        db_d    = db_q;
        led_d   = led_q;
        press_d = '0;
        long_d  = '0;
        for (int c = 0; c < CH; c++) begin
            dcnt_d[c] = '0;
            lcnt_d[c] = '0;
        end

        for (int c = 0; c < CH; c++) begin
            // Any sample equal to the stable level restarts the debounce window.
            if (s2_q[c] != db_q[c]) begin
                if (dcnt_q[c] == DCNT_LAST) begin
                    db_d[c]    = s2_q[c];
                    press_d[c] = s2_q[c];
                end else begin
                    dcnt_d[c] = dcnt_q[c] + 1'b1;
                end
            end

            if (db_q[c]) begin
                lcnt_d[c] = (lcnt_q[c] == LCNT_MAX) ? lcnt_q[c] : lcnt_q[c] + 1'b1;
                long_d[c] = (lcnt_q[c] == LCNT_LAST);
            end

            case (mode)
                MODE_TOGGLE:      if (press_d[c]) led_d[c] = ~led_q[c];
                MODE_MOMENTARY:   led_d[c] = db_d[c];
                MODE_LONG_TOGGLE: if (long_d[c]) led_d[c] = ~led_q[c];
                default:          led_d[c] = led_q[c];
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            led_q   <= {CH{LED_RST}};
            press_q <= '0;
            long_q  <= '0;
            for (int c = 0; c < CH; c++) begin
                dcnt_q[c] <= '0;
                lcnt_q[c] <= '0;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            db_q    <= db_d;
            led_q   <= led_d;
            press_q <= press_d;
            long_q  <= long_d;
            for (int c = 0; c < CH; c++) begin
                dcnt_q[c] <= dcnt_d[c];
                lcnt_q[c] <= lcnt_d[c];
            end
        end
    end

    assign led       = led_q;
    assign key_press = press_q;
    assign key_long  = long_q;

endmodule

// File: tb/tb_touch_led_array.sv
// Bench for touch_led_array: directed scenarios plus random key traffic against a sample-history reference model.
module tb_touch_led_array;

    localparam int CH   = 4;
    localparam int DEB  = 4;
    localparam int LONG = 16;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [CH-1:0] touch_key = '0;
    logic [1:0]    mode      = 2'b00;
    logic [CH-1:0] led, key_press, key_long;

    int n_checks = 0;
    int n_errors = 0;

    always #5 sys_clk = ~sys_clk;

    touch_led_array #(
        .CH(CH), .DEBOUNCE_CYC(DEB), .LONG_CYC(LONG), .LED_RST(1'b1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .touch_key(touch_key),
        .mode(mode), .led(led), .key_press(key_press), .key_long(key_long)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: raw samples per edge since reset; a level is accepted once the
    // last DEB synchronised samples all disagree with the current stable level.
    bit [CH-1:0] hist[$];
    int          n_edge;
    bit [CH-1:0] m_db, m_led, m_press, m_long;
    int          rise_at[CH];

    function automatic bit raw_at(int idx, int c);
        if (idx < 0) return 1'b0;
        return hist[idx][c];
    endfunction

    task automatic model_reset();
        hist.delete();
        n_edge  = 0;
        m_db    = '0;
        m_led   = '1;
        m_press = '0;
        m_long  = '0;
        for (int c = 0; c < CH; c++) rise_at[c] = -1;
    endtask

    task automatic model_step();
        bit [CH-1:0] db_new;
        for (int c = 0; c < CH; c++) begin
            bit flip = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (raw_at(n_edge - 2 - j, c) == m_db[c]) flip = 1'b0;
            db_new[c]  = flip ? ~m_db[c] : m_db[c];
            m_press[c] = flip && !m_db[c];
            m_long[c]  = m_db[c] && (rise_at[c] >= 0) && (n_edge - rise_at[c] == LONG);
            if (m_press[c]) rise_at[c] = n_edge;
            case (mode)
                2'b00:   if (m_press[c]) m_led[c] = ~m_led[c];
                2'b01:   m_led[c] = db_new[c];
                2'b10:   if (m_long[c]) m_led[c] = ~m_led[c];
                default: ;
            endcase
        end
        m_db = db_new;
        hist.push_back(touch_key);
        n_edge++;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        check_eq("led", 32'(led), 32'(m_led));
        check_eq("key_press", 32'(key_press), 32'(m_press));
        check_eq("key_long", 32'(key_long), 32'(m_long));
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        check_eq("rst_led", 32'(led), 32'hF);
        check_eq("rst_press", 32'(key_press), 32'h0);
        check_eq("rst_long", 32'(key_long), 32'h0);
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        int first, pcnt, lcnt, lfirst, on_cnt;
        int run[CH];
        logic [CH-1:0] cap;

        model_reset();
        do_reset();

        // 1: toggle on press, release ignored
        touch_key[0] = 1'b1;
        first = -1; pcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (key_press[0]) begin pcnt++; if (first < 0) first = i; end
        end
        check_eq("s1_led_held", 32'(led), 32'hE);
        touch_key[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); if (key_press[0]) pcnt++; end
        check_eq("s1_press_latency", 32'(first), 32'd5);
        check_eq("s1_press_count", 32'(pcnt), 32'd1);
        check_eq("s1_led_released", 32'(led), 32'hE);

        // 2: short glitch and bounce are rejected
        pcnt = 0;
        touch_key[1] = 1'b1; repeat (3) begin tick(); if (key_press[1]) pcnt++; end
        touch_key[1] = 1'b0; repeat (6) begin tick(); if (key_press[1]) pcnt++; end
        touch_key[1] = 1'b1; repeat (2) begin tick(); if (key_press[1]) pcnt++; end
        touch_key[1] = 1'b0; repeat (1) begin tick(); if (key_press[1]) pcnt++; end
        touch_key[1] = 1'b1; repeat (2) begin tick(); if (key_press[1]) pcnt++; end
        touch_key[1] = 1'b0; repeat (8) begin tick(); if (key_press[1]) pcnt++; end
        check_eq("s2_press_count", 32'(pcnt), 32'd0);
        check_eq("s2_led1", 32'(led[1]), 32'd1);

        // 3: long-toggle mode
        mode = 2'b10;
        touch_key[2] = 1'b1;
        pcnt = 0; lcnt = 0; lfirst = -1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (key_press[2]) pcnt++;
            if (key_long[2]) begin lcnt++; if (lfirst < 0) lfirst = i; end
        end
        touch_key[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); if (key_long[2]) lcnt++; end
        check_eq("s3_press_count", 32'(pcnt), 32'd1);
        check_eq("s3_long_count", 32'(lcnt), 32'd1);
        check_eq("s3_long_time", 32'(lfirst), 32'd21);
        check_eq("s3_led2_after_long", 32'(led[2]), 32'd0);
        touch_key[2] = 1'b1;
        lcnt = 0; pcnt = 0;
        repeat (10) begin tick(); if (key_long[2]) lcnt++; if (key_press[2]) pcnt++; end
        touch_key[2] = 1'b0;
        repeat (12) begin tick(); if (key_long[2]) lcnt++; end
        check_eq("s3_short_long_count", 32'(lcnt), 32'd0);
        check_eq("s3_short_press_count", 32'(pcnt), 32'd1);
        check_eq("s3_led2_after_short", 32'(led[2]), 32'd0);

        // 4: momentary mode follows debounced level
        mode = 2'b01;
        tick();
        check_eq("s4_enter_momentary", 32'(led), 32'h0);
        touch_key[3] = 1'b1;
        on_cnt = 0;
        repeat (10) begin tick(); if (led[3]) on_cnt++; end
        touch_key[3] = 1'b0;
        repeat (12) begin tick(); if (led[3]) on_cnt++; end
        check_eq("s4_led3_on_cycles", 32'(on_cnt), 32'd10);

        // 5: simultaneous presses
        mode = 2'b00;
        do_reset();
        touch_key = '1;
        cap = '0;
        repeat (8) begin tick(); if (key_press != '0 && cap == '0) cap = key_press; end
        check_eq("s5_press_all", 32'(cap), 32'hF);
        check_eq("s5_led_all", 32'(led), 32'h0);
        touch_key = '0;
        repeat (10) tick();

        // 6: reset mid long-press with key still held
        mode = 2'b10;
        touch_key[0] = 1'b1;
        repeat (12) tick();
        do_reset();
        first = -1; lfirst = -1; lcnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (key_press[0] && first < 0) first = i;
            if (key_long[0]) begin lcnt++; if (lfirst < 0) lfirst = i; end
        end
        check_eq("s6_press_time", 32'(first), 32'd5);
        check_eq("s6_long_time", 32'(lfirst), 32'd21);
        check_eq("s6_long_count", 32'(lcnt), 32'd1);
        touch_key[0] = 1'b0;
        repeat (10) tick();

        // Random traffic with occasional mode switches
        for (int c = 0; c < CH; c++) run[c] = $urandom_range(1, 30);
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < CH; c++) begin
                if (run[c] == 0) begin
                    touch_key[c] = ~touch_key[c];
                    run[c] = $urandom_range(1, 30);
                end
                run[c]--;
            end
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
